// File: rtl/cacheline_adapter_pkg.sv
// cacheline_adapter_pkg: state enum, default widths and beat-count helper for cacheline_adapter
package cacheline_adapter_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  localparam int LINE_W_DEF = 256;
  localparam int BURST_W_DEF = 64;
  localparam int ADDR_W_DEF = 32;
  function automatic int beats_f(input int line_w, input int burst_w);
    return line_w / burst_w;
  endfunction
endpackage

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: cache line <-> memory burst bridge (cache: read_i/write_i/address_i/line_i/line_o/resp_o, memory: address_o/read_o/write_o/burst_o/burst_i/resp_i), CACHELINE_ADAPTER_ALIGN_EN forces line-aligned address_o
module cacheline_adapter
  import cacheline_adapter_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int BURST_W = BURST_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
);
  localparam int BEATS = beats_f(LINE_W, BURST_W);
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic [LINE_W-1:0] line_buf;
  logic [ADDR_W-1:0] addr_in;
  logic last;
`ifdef CACHELINE_ADAPTER_ALIGN_EN
  localparam int AB = $clog2(LINE_W / 8);
  assign addr_in = {address_i[ADDR_W-1:AB], {AB{1'b0}}};
`else
  assign addr_in = address_i;
`endif
  assign last = cnt == CW'(BEATS - 1);
  assign burst_o = write_o ? line_buf[int'(cnt)*BURST_W +: BURST_W] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      line_o <= '0;
      line_buf <= '0;
      address_o <= '0;
      read_o <= 1'b0;
      write_o <= 1'b0;
      resp_o <= 1'b0;
    end else begin
      resp_o <= 1'b0;
      case (state)
        IDLE: if (write_i || read_i) begin
          address_o <= addr_in;
          cnt <= '0;
          if (write_i) begin
            state <= WRITE;
            write_o <= 1'b1;
            line_buf <= line_i;
          end else begin
            state <= READ;
            read_o <= 1'b1;
          end
        end
        READ: if (resp_i) begin
          line_o[int'(cnt)*BURST_W +: BURST_W] <= burst_i;
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            state <= DONE;
            read_o <= 1'b0;
            resp_o <= 1'b1;
          end
        end
        WRITE: if (resp_i) begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            state <= DONE;
            write_o <= 1'b0;
            resp_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter: directed self-checking bench for cacheline_adapter
module tb_cacheline_adapter;
  localparam int LW = 256;
  localparam int BW = 64;
  localparam int AW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic read_i = 1'b0;
  logic write_i = 1'b0;
  logic resp_i = 1'b0;
  logic [AW-1:0] address_i = '0;
  logic [LW-1:0] line_i = '0;
  logic [BW-1:0] burst_i = '0;
  logic [LW-1:0] line_o;
  logic resp_o;
  logic [AW-1:0] address_o;
  logic read_o;
  logic write_o;
  logic [BW-1:0] burst_o;
  int checks = 0;
  int errors = 0;
  cacheline_adapter dut (
    .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i), .address_i(address_i),
    .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a);
`ifdef CACHELINE_ADAPTER_ALIGN_EN
    return a & ~32'h1F;
`else
    return a;
`endif
  endfunction
  task automatic fill(input logic [AW-1:0] a, input logic [LW-1:0] l);
    read_i = 1'b1;
    address_i = a;
    tick;
    check("fill_addr", address_o, exp_addr(a));
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1;
      burst_i = l[i*BW +: BW];
      check("fill_read_o", read_o, 1);
      check("fill_resp_early", resp_o, 0);
      tick;
    end
    resp_i = 1'b0;
    burst_i = '0;
    read_i = 1'b0;
    check("fill_resp", resp_o, 1);
    check("fill_read_off", read_o, 0);
    check("fill_line", line_o, l);
    check("fill_addr_hold", address_o, exp_addr(a));
    tick;
    check("fill_resp_once", resp_o, 0);
  endtask
  initial begin
    logic [LW-1:0] l1, wb, l2, l3;
    int beat;
    l1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    wb = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    l2 = {64'h0123_4567_89AB_CDEF, 64'h0F0F_0F0F_0F0F_0F0F, 64'h5555_5555_5555_5555, 64'hDEAD_BEEF_CAFE_F00D};
    l3 = {64'h8888_7777_6666_5555, 64'h4444_3333_2222_1111, 64'h1357_9BDF_2468_ACE0, 64'hFEDC_BA98_7654_3210};
    tick;
    tick;
    check("rst_line", line_o, 0);
    check("rst_resp", resp_o, 0);
    check("rst_addr", address_o, 0);
    check("rst_read", read_o, 0);
    check("rst_write", write_o, 0);
    check("rst_burst", burst_o, 0);
    rst = 1'b0;
    tick;
    fill(32'h0000_1040, l1);
    write_i = 1'b1;
    address_i = 32'h0000_2000;
    line_i = wb;
    tick;
    beat = 0;
    for (int c = 1; c <= 9; c++) begin
      resp_i = (c == 2 || c == 5 || c == 6 || c == 9);
      check("wb_write_o", write_o, 1);
      check("wb_read_o", read_o, 0);
      check("wb_resp_early", resp_o, 0);
      check("wb_burst", burst_o, wb[beat*BW +: BW]);
      if (resp_i) beat++;
      tick;
    end
    resp_i = 1'b0;
    write_i = 1'b0;
    check("wb_resp", resp_o, 1);
    check("wb_write_off", write_o, 0);
    check("wb_line_kept", line_o, l1);
    tick;
    check("wb_resp_once", resp_o, 0);
    read_i = 1'b1;
    write_i = 1'b1;
    line_i = l2;
    tick;
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1;
      check("both_read_o", read_o, 0);
      check("both_write_o", write_o, 1);
      check("both_burst", burst_o, l2[i*BW +: BW]);
      tick;
    end
    resp_i = 1'b0;
    read_i = 1'b0;
    write_i = 1'b0;
    check("both_resp", resp_o, 1);
    check("both_read_off", read_o, 0);
    check("both_line_kept", line_o, l1);
    tick;
    check("both_resp_once", resp_o, 0);
    read_i = 1'b1;
    address_i = 32'h0000_3000;
    tick;
    for (int i = 0; i < 2; i++) begin
      resp_i = 1'b1;
      burst_i = l2[i*BW +: BW];
      tick;
    end
    resp_i = 1'b0;
    read_i = 1'b0;
    rst = 1'b1;
    tick;
    check("abort_read_o", read_o, 0);
    check("abort_line", line_o, 0);
    check("abort_resp", resp_o, 0);
    check("abort_addr", address_o, 0);
    rst = 1'b0;
    tick;
    check("abort_no_resp", resp_o, 0);
    check("abort_idle", read_o, 0);
    fill(32'h0000_105C, l3);
    resp_i = 1'b1;
    burst_i = '1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("stray_line", line_o, l3);
      check("stray_read", read_o, 0);
      check("stray_write", write_o, 0);
      check("stray_resp", resp_o, 0);
    end
    resp_i = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
